// File: rtl/ps2_uart_bridge.sv
// ps2_uart_bridge: PS/2 scan bytes to UART characters (ASCII or hex dump) through a character FIFO.
// Optional caps-lock support under KB_CAPS_LOCK_EN.
module ps2_uart_bridge #(
  parameter int FIFO_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_tick,
  input  logic [7:0] scan_code,
  input  logic       hex_mode,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       ovf,
  output logic       shift_on,
  output logic       caps_on
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} st_t;
  st_t st, n_st;
  logic hex_q, busy, take, mode, is_pfx, is_shift, make, pop, push_ok, empty, full;
  logic [31:0] f_buf, n_buf;
  logic [2:0] f_len, n_len;
  logic [8:0] asc;
  logic [7:0] mem [0:(1<<FIFO_W)-1];
  logic [FIFO_W-1:0] wp, rp;
  logic [FIFO_W:0] cnt;

  function automatic logic [7:0] hx(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // Returns {valid, char}; letters are lowercase unless up is set.
  function automatic logic [8:0] lookup(input logic [7:0] c, input logic up);
    logic [8:0] r;
    r = 9'h0;
    case (c)
      8'h1C: r = 9'h161; 8'h32: r = 9'h162; 8'h21: r = 9'h163; 8'h23: r = 9'h164;
      8'h24: r = 9'h165; 8'h2B: r = 9'h166; 8'h34: r = 9'h167; 8'h33: r = 9'h168;
      8'h43: r = 9'h169; 8'h3B: r = 9'h16A; 8'h42: r = 9'h16B; 8'h4B: r = 9'h16C;
      8'h3A: r = 9'h16D; 8'h31: r = 9'h16E; 8'h44: r = 9'h16F; 8'h4D: r = 9'h170;
      8'h15: r = 9'h171; 8'h2D: r = 9'h172; 8'h1B: r = 9'h173; 8'h2C: r = 9'h174;
      8'h3C: r = 9'h175; 8'h2A: r = 9'h176; 8'h1D: r = 9'h177; 8'h22: r = 9'h178;
      8'h35: r = 9'h179; 8'h1A: r = 9'h17A;
      8'h45: r = 9'h130; 8'h16: r = 9'h131; 8'h1E: r = 9'h132; 8'h26: r = 9'h133;
      8'h25: r = 9'h134; 8'h2E: r = 9'h135; 8'h36: r = 9'h136; 8'h3D: r = 9'h137;
      8'h3E: r = 9'h138; 8'h46: r = 9'h139;
      8'h29: r = 9'h120; 8'h5A: r = 9'h10D; 8'h66: r = 9'h108;
      default: r = 9'h0;
    endcase
    if (up && r[7:0] >= 8'h61) r[5] = 1'b0;
    return r;
  endfunction

  always_comb begin
    busy = f_len != 3'd0;
    take = scan_tick && !busy;
    mode = st == IDLE ? hex_mode : hex_q;
    is_pfx = scan_code == 8'hF0 || scan_code == 8'hE0;
    is_shift = scan_code == 8'h12 || scan_code == 8'h59;
    make = st == IDLE && !is_pfx;
    asc = lookup(scan_code, shift_on ^ caps_on);
    n_st = st == IDLE ? (scan_code == 8'hF0 ? BRK : scan_code == 8'hE0 ? EXT : IDLE)
         : st == EXT ? (scan_code == 8'hF0 ? EXT_BRK : IDLE) : IDLE;
    // First character sits in the low byte and is shifted out one per cycle.
    n_buf = mode ? {is_pfx ? 16'h0020 : 16'h0A0D, hx(scan_code[3:0]), hx(scan_code[7:4])}
                 : {24'h0, asc[7:0]};
    n_len = mode ? (is_pfx ? 3'd3 : 3'd4) : (make && asc[8] ? 3'd1 : 3'd0);
    empty = cnt == '0;
    full = cnt[FIFO_W];
    pop = !empty && !tx_full;
    push_ok = busy && (!full || pop);
    wr_uart = pop;
    w_data = empty ? 8'h00 : mem[rp];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      hex_q <= 1'b0;
      f_buf <= '0;
      f_len <= 3'd0;
      shift_on <= 1'b0;
      ovf <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (busy) begin
        f_buf <= f_buf >> 8;
        f_len <= f_len - 3'd1;
      end
      if (take) begin
        st <= n_st;
        hex_q <= mode;
        f_buf <= n_buf;
        f_len <= n_len;
        if (!mode && make && is_shift) shift_on <= 1'b1;
        else if (!mode && st == BRK && is_shift) shift_on <= 1'b0;
      end
      if ((scan_tick && busy) || (busy && full && !pop)) ovf <= 1'b1;
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{FIFO_W{1'b0}}, push_ok} - {{FIFO_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) if (push_ok) mem[wp] <= f_buf[7:0];

`ifdef KB_CAPS_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) caps_on <= 1'b0;
    else if (take && !mode && make && scan_code == 8'h58) caps_on <= !caps_on;
  end
`else
  assign caps_on = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_uart_bridge.sv
// tb_ps2_uart_bridge: vector table, directed corner sequences and random stimulus against a queue-based model.
module tb_ps2_uart_bridge;
  localparam int FW = 2;
  localparam int CAP = 1 << FW;
  logic clk = 0, reset = 0, scan_tick = 0, hex_mode = 0, tx_full = 0;
  logic [7:0] scan_code = 0;
  logic wr_uart, ovf, shift_on, caps_on;
  logic [7:0] w_data;
  int checks = 0, failures = 0, cyc = 0, first_wr = -1;
  logic [7:0] got[$], fq[$], mq[$];
  bit m_ovf, m_shift, m_caps, m_e0, m_f0, m_hex;
  logic [7:0] lcode[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                            8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                            8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dcode[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  typedef struct {logic [7:0] code; logic sh; int len; logic [7:0] ch;} vec_t;
  vec_t tbl[10];

  ps2_uart_bridge #(.FIFO_W(FW)) dut (
    .clk(clk), .reset(reset), .scan_tick(scan_tick), .scan_code(scan_code), .hex_mode(hex_mode),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .ovf(ovf), .shift_on(shift_on),
    .caps_on(caps_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", n, a, e, cyc);
    end
  endtask

  task automatic chk_seq(input string n, input int len, input logic [63:0] e);
    bit ok;
    string s = "";
    ok = got.size() == len;
    for (int i = 0; i < got.size(); i++) s = {s, $sformatf("%h ", got[i])};
    for (int i = 0; ok && i < len; i++) if (got[i] !== e[8*(len-1-i) +: 8]) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=[ %s] exp=%0d chars %h", n, s, len, e);
    end
  endtask

  function automatic logic [7:0] hexch(input logic [3:0] n);
    return n < 10 ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction

  task automatic decode(input logic [7:0] c, input logic h);
    bit idle = !m_e0 && !m_f0;
    bit pfx = c == 8'hF0 || c == 8'hE0;
    if (idle) m_hex = h;
    if (m_hex) begin
      fq.push_back(hexch(c[7:4]));
      fq.push_back(hexch(c[3:0]));
      if (pfx) fq.push_back(8'h20);
      else begin fq.push_back(8'h0D); fq.push_back(8'h0A); end
    end else if (!pfx) begin
      if (idle) begin
        if (c == 8'h12 || c == 8'h59) m_shift = 1;
`ifdef KB_CAPS_LOCK_EN
        else if (c == 8'h58) m_caps = !m_caps;
`endif
        else begin
          for (int i = 0; i < 26; i++)
            if (lcode[i] == c) fq.push_back(8'((m_shift ^ m_caps) ? 8'h41 + i : 8'h61 + i));
          for (int i = 0; i < 10; i++) if (dcode[i] == c) fq.push_back(8'(8'h30 + i));
          if (c == 8'h29) fq.push_back(8'h20);
          if (c == 8'h5A) fq.push_back(8'h0D);
          if (c == 8'h66) fq.push_back(8'h08);
        end
      end else if (m_f0 && !m_e0 && (c == 8'h12 || c == 8'h59)) m_shift = 0;
    end
    if (m_f0) begin m_f0 = 0; m_e0 = 0; end
    else if (c == 8'hF0) m_f0 = 1;
    else if (c == 8'hE0 && !m_e0) m_e0 = 1;
    else m_e0 = 0;
  endtask

  task automatic model_step(input logic t, input logic [7:0] c, input logic h, input logic f);
    bit busy = fq.size() != 0;
    bit pop = mq.size() != 0 && !f;
    bit full = mq.size() == CAP;
    logic [7:0] x;
    if (pop) void'(mq.pop_front());
    if (busy) begin
      x = fq.pop_front();
      if (!full || pop) mq.push_back(x);
      else m_ovf = 1;
    end
    if (t) begin
      if (busy) m_ovf = 1;
      else decode(c, h);
    end
  endtask

  task automatic step(input logic t, input logic [7:0] c, input logic h, input logic f);
    scan_tick = t; scan_code = c; hex_mode = h; tx_full = f;
    #1;
    chk("wr_uart", wr_uart, (mq.size() != 0 && !f));
    chk("w_data", w_data, mq.size() != 0 ? mq[0] : 8'h00);
    chk("ovf", ovf, m_ovf);
    chk("shift_on", shift_on, m_shift);
    chk("caps_on", caps_on, m_caps);
    if (wr_uart) begin
      got.push_back(w_data);
      if (first_wr < 0) first_wr = cyc;
    end
    @(posedge clk);
    model_step(t, c, h, f);
    @(negedge clk);
    scan_tick = 0;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1; scan_tick = 0; tx_full = 0;
    #1;
    chk("rst_wr_uart", wr_uart, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_shift", shift_on, 0);
    chk("rst_caps", caps_on, 0);
    fq.delete(); mq.delete();
    m_ovf = 0; m_shift = 0; m_caps = 0; m_e0 = 0; m_f0 = 0; m_hex = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic drain();
    int b = 0;
    while ((fq.size() != 0 || mq.size() != 0) && b < 60) begin step(0, 8'h00, 0, 0); b++; end
    if (b >= 60) begin failures++; $display("FAIL drain_timeout cyc=%0d", cyc); end
    step(0, 8'h00, 0, 0);
  endtask

  task automatic send(input logic [7:0] c, input logic h);
    step(1, c, h, 0);
    drain();
  endtask

  function automatic logic [7:0] rnd_code();
    int r = $urandom_range(0, 9);
    if (r == 0) return 8'hF0;
    if (r == 1) return 8'hE0;
    if (r == 2) return $urandom_range(0, 1) ? 8'h12 : 8'h59;
    if (r == 3) return 8'h58;
    if (r < 7) return lcode[$urandom_range(0, 25)];
    if (r == 7) return dcode[$urandom_range(0, 9)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    logic h;
    int n0;
    tbl[0] = '{8'h1C, 1'b0, 1, 8'h61};
    tbl[1] = '{8'h1A, 1'b1, 1, 8'h5A};
    tbl[2] = '{8'h45, 1'b0, 1, 8'h30};
    tbl[3] = '{8'h46, 1'b1, 1, 8'h39};
    tbl[4] = '{8'h16, 1'b0, 1, 8'h31};
    tbl[5] = '{8'h29, 1'b0, 1, 8'h20};
    tbl[6] = '{8'h5A, 1'b0, 1, 8'h0D};
    tbl[7] = '{8'h66, 1'b0, 1, 8'h08};
    tbl[8] = '{8'h2B, 1'b1, 1, 8'h46};
    tbl[9] = '{8'h0E, 1'b0, 0, 8'h00};
    #2;
    do_reset();

    foreach (tbl[i]) begin
      got.delete();
      if (tbl[i].sh) send(8'h12, 0);
      send(tbl[i].code, 0);
      if (tbl[i].sh) begin send(8'hF0, 0); send(8'h12, 0); end
      chk_seq($sformatf("tbl%0d", i), tbl[i].len, {56'h0, tbl[i].ch});
    end

    got.delete();
    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    chk_seq("make_break", 1, 64'h61);
    chk("make_break_shift", shift_on, 0);

    got.delete();
    send(8'h12, 0);
    chk("shift_held", shift_on, 1);
    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h12, 0);
    chk("shift_released", shift_on, 0);
    send(8'h1C, 0);
    chk_seq("shift_seq", 2, 64'h4161);

    got.delete();
    first_wr = -1;
    n0 = cyc;
    send(8'hF0, 1); send(8'h1C, 1);
    chk_seq("hex_brk", 7, 64'h46302031430D0A);
    chk("hex_latency", 8'(first_wr - n0), 8'd2);

    do_reset();
    got.delete();
    step(1, 8'h1C, 1, 1);
    repeat (4) step(0, 8'h00, 1, 1);
    step(1, 8'h32, 1, 1);
    repeat (5) step(0, 8'h00, 1, 1);
    chk("full_ovf", ovf, 1);
    chk_seq("full_held", 0, 64'h0);
    drain();
    chk_seq("full_drain", 4, 64'h31430D0A);

    do_reset();
    got.delete();
    step(1, 8'h1C, 1, 0);
    step(1, 8'h32, 1, 0);
    drain();
    chk_seq("busy_drop", 4, 64'h31430D0A);
    chk("busy_ovf", ovf, 1);

    do_reset();
    got.delete();
    send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0); send(8'h1C, 0);
`ifdef KB_CAPS_LOCK_EN
    chk("caps_state", caps_on, 1);
    chk_seq("caps_char", 1, 64'h41);
`else
    chk("caps_state", caps_on, 0);
    chk_seq("caps_char", 1, 64'h61);
`endif

    do_reset();
    step(1, 8'h1C, 1, 0);
    step(0, 8'h00, 1, 0);
    do_reset();
    got.delete();
    drain();
    chk_seq("reset_discard", 0, 64'h0);
    send(8'hE0, 0);
    do_reset();
    got.delete();
    send(8'h1C, 0);
    chk_seq("reset_prefix", 1, 64'h61);

    h = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 0) do_reset();
      if ($urandom_range(0, 49) == 0) h = !h;
      step($urandom_range(0, 2) == 0, rnd_code(), h, $urandom_range(0, 3) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_uart_bridge.md
# ps2_uart_bridge

Parametrised PS/2-scan-byte to UART-character bridge. It sits between a PS/2 receiver (one strobe per scan byte) and a UART transmitter (write/full handshake). Decoding runs in one of two run-time modes: ASCII key translation with shift tracking, or hex dump of raw scan bytes. Output characters are buffered in an internal FIFO of configurable depth so that multi-character events never stall the keyboard side.

## Interface
Parameters:
- FIFO_W, 4, character FIFO address width; the FIFO holds 2^FIFO_W characters.

Ports:
- clk  in  1  system clock; the block has one clock domain.
- reset  in  1  reset, asynchronous and active-high.
- scan_tick  in  1  one-cycle strobe; scan_code is valid in this cycle.
- scan_code  in  8  scan byte from the PS/2 receiver.
- hex_mode  in  1  selects the mode: 0 = ASCII translation, 1 = hex dump.
- tx_full  in  1  UART transmit buffer full.
- wr_uart  out  1  one-cycle write strobe to the UART.
- w_data  out  8  character to the UART; valid when wr_uart=1.
- ovf  out  1  sticky; a scan byte or a character was dropped.
- shift_on  out  1  a shift key (0x12 or 0x59) is currently held.
- caps_on  out  1  caps-lock state.

## Operation
- Decoder FSM states: IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (after 0xE0 0xF0).
  - IDLE: 0xF0 goes to BRK; 0xE0 goes to EXT; any other byte is a make code and returns to IDLE.
  - EXT: 0xF0 goes to EXT_BRK; any other byte goes to IDLE.
  - BRK and EXT_BRK: the next byte goes to IDLE.
- hex_mode is sampled on each scan_tick that arrives with the decoder in IDLE. The mode is held until the decoder returns to IDLE.
- ASCII mode:
  - Make of 0x12 or 0x59 sets shift_on.
  - Break of 0x12 or 0x59 clears shift_on.
  - Other make codes in IDLE are looked up:
    - letters: 0x1C→'a' … lowercase, or uppercase when shift_on XOR caps_on;
    - digits: 0x45→'0', 0x16→'1' … 0x46→'9';
    - 0x29→0x20, 0x5A→0x0D, 0x66→0x08.
  - Unmapped codes, all break codes and all extended sequences produce no output.
  - Typematic repeats (a repeated make code) produce repeated characters.
- Hex mode:
  - Every byte is output as two uppercase hex ASCII digits.
  - After 0xE0 or 0xF0, a space (0x20) follows: 3 characters.
  - After any other byte, 0x0D 0x0A follows: 4 characters.
- Formatter: pushes its characters into the FIFO one per cycle, in the order given above. It is busy until the last character is pushed.
- Drop rules (each sets ovf; ovf clears only on reset):
  - A scan_tick while the formatter is busy drops that byte. The decoder state is unchanged.
  - A push while the FIFO is full drops that character. The formatter continues with its next character.
- Drain:
  - wr_uart = FIFO not empty AND tx_full=0, combinational.
  - w_data is the FIFO head, forced to 0x00 when the FIFO is empty.
  - The FIFO pops on each cycle in which wr_uart=1.
  - A push and a pop in the same cycle are both performed, including when the FIFO is full.

## Timing
- Reset values: wr_uart=0, w_data=0x00, ovf=0, shift_on=0, caps_on=0, decoder in IDLE, formatter idle, FIFO empty.
- Reset mid-sequence discards the partial sequence and all buffered characters.
- scan_tick in cycle N:
  - The decoder state and shift_on/caps_on update at the edge ending cycle N.
  - The first character is pushed at the edge ending cycle N+1.
  - wr_uart can assert from cycle N+2.
- Hex final byte: pushes occur at the edges ending N+1 through N+4.
- Throughput: one character per cycle when tx_full=0.
- While tx_full=1, wr_uart=0 and the FIFO holds its contents.
- Pointers wrap modulo 2^FIFO_W. The count register is FIFO_W+1 bits wide so that full and empty are distinguished.

## Configuration
- KB_CAPS_LOCK_EN defined:
  - Make of 0x58 toggles caps_on.
  - Letter case follows shift_on XOR caps_on.
- KB_CAPS_LOCK_EN undefined:
  - caps_on is tied to 0.
  - 0x58 is treated as unmapped.
  - Letter case follows shift_on only.

## Test plan
- ASCII bytes 0x1C, 0xF0, 0x1C → exactly one write, 0x61; shift_on stays 0.
- ASCII 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12, 0x1C → writes 0x41 then 0x61; shift_on high only between 0x12 and F0 12.
- Hex mode, bytes 0xF0, 0x1C → writes 0x46 0x30 0x20 0x31 0x43 0x0D 0x0A; first write at cycle N+2 after the 0xF0 strobe.
- FIFO_W=2, tx_full held 1, hex byte 0x1C then byte 0x32 → first 4 characters retained, the next 4 dropped, ovf=1. Releasing tx_full then yields 0x31 0x43 0x0D 0x0A.
- scan_tick on two consecutive cycles in hex mode → second byte dropped, ovf=1, only the first byte's characters are emitted.
- With KB_CAPS_LOCK_EN, ASCII 0x58, 0xF0, 0x58, 0x1C → caps_on=1, write 0x41. Without the macro → caps_on=0, write 0x61.
